// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the instruction-memory address and the IF/ID register.
// Handles redirect, stall and halt, and counts the valid fetches loaded into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic [31:0]      if_id_instr,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [31:0]      ifpc_q, ifpc_d;
  logic [31:0]      ifpc4_q, ifpc4_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  logic             redirect_pc_unused;

  assign pc_plus4           = pc_q + 32'd4;
  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
      ifpc_d  = '0;
      ifpc4_d = '0;
      instr_d = NOP_INSTR;
      state_d = RUN;
    end else if (!stall) begin
      unique case (state_q)
        BOOT: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = RUN;
        end
        RUN: begin
          valid_d = 1'b1;
          ifpc_d  = pc_q;
          ifpc4_d = pc_plus4;
          instr_d = imem_rdata;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // HALT word is delivered like any fetch; only the PC stops advancing.
          if (imem_rdata == HALT_INSTR) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus4;
          end
        end
        HALTED: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
      instr_q <= NOP_INSTR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign if_id_instr    = instr_q;
  assign halted         = (state_q == HALTED);
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with an asynchronous ROM model and a 4-bit fetch counter.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic        if_id_valid, halted;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic [3:0]  fetch_count;
  logic        halt_en;
  logic [31:0] halt_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  if_fetch_stage #(.CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_instr    (if_id_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    if (a == 32'h4) return 32'h0010_8113;
    return a ^ 32'h1234_0013;
  endfunction

  always_comb begin
    if (halt_en && imem_addr == halt_addr) imem_rdata = 32'hFFFF_FFFF;
    else imem_rdata = rom(imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] pc4, input logic [31:0] ins);
    check({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
    check({tag, ".pc"}, if_id_pc, pc);
    check({tag, ".pc4"}, if_id_pc_plus4, pc4);
    check({tag, ".instr"}, if_id_instr, ins);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_en = 1'b0; halt_addr = 32'h20;
    step(); step();
    check_ifid("rst", 1'b0, 32'h0, 32'h0, 32'h13);
    check("rst.halted", {31'b0, halted}, 32'h0);
    check("rst.cnt", {28'b0, fetch_count}, 32'h0);
    check("rst.addr", imem_addr, 32'h0);

    // 1: boot bubble then sequential fetch
    rst = 1'b0;
    step();
    check("boot.addr", imem_addr, 32'h0);
    check("boot.valid", {31'b0, if_id_valid}, 32'h0);
    step();
    check_ifid("f0", 1'b1, 32'h0, 32'h4, 32'h00A0_0093);
    check("f0.addr", imem_addr, 32'h4);
    step();
    check_ifid("f1", 1'b1, 32'h4, 32'h8, 32'h0010_8113);
    check("f1.cnt", {28'b0, fetch_count}, 32'h2);
    step(); step();
    check("pre_stall.addr", imem_addr, 32'h10);
    check("pre_stall.cnt", {28'b0, fetch_count}, 32'h4);

    // 2: stall freezes everything
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.addr", imem_addr, 32'h10);
      check("stall.ifpc", if_id_pc, 32'hC);
      check("stall.cnt", {28'b0, fetch_count}, 32'h4);
    end
    stall = 1'b0;
    step();
    check_ifid("unstall", 1'b1, 32'h10, 32'h14, 32'h1234_0003);
    check("unstall.cnt", {28'b0, fetch_count}, 32'h5);

    // 3: redirect wins over stall; low address bits dropped
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    check("redir.addr", imem_addr, 32'h100);
    check_ifid("redir", 1'b0, 32'h0, 32'h0, 32'h13);
    check("redir.cnt", {28'b0, fetch_count}, 32'h5);
    step();
    check_ifid("redir_tgt", 1'b1, 32'h100, 32'h104, 32'h1234_0113);

    // 4: halt at 0x20, then resume at 0x40
    halt_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    step();
    check_ifid("halt", 1'b1, 32'h20, 32'h24, 32'hFFFF_FFFF);
    check("halt.halted", {31'b0, halted}, 32'h1);
    check("halt.addr", imem_addr, 32'h20);
    check("halt.cnt", {28'b0, fetch_count}, 32'h7);
    step();
    check_ifid("halted_bub", 1'b0, 32'h20, 32'h24, 32'h13);
    check("halted_bub.addr", imem_addr, 32'h20);
    check("halted_bub.cnt", {28'b0, fetch_count}, 32'h7);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("resume.halted", {31'b0, halted}, 32'h0);
    check("resume.addr", imem_addr, 32'h40);
    step();
    check_ifid("resume", 1'b1, 32'h40, 32'h44, 32'h1234_0053);
    check("resume.cnt", {28'b0, fetch_count}, 32'h8);

    // 5: PC wrap and counter wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'hEDCB_FFEF);
    check("wrap.addr", imem_addr, 32'h0);
    check("wrap.cnt", {28'b0, fetch_count}, 32'h9);
    for (int i = 0; i < 6; i++) step();
    check("cnt15", {28'b0, fetch_count}, 32'hF);
    step();
    check("cnt_wrap", {28'b0, fetch_count}, 32'h0);

    // 6: stall in HALTED keeps the HALT word; reset during stall restores everything
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step();
    redirect_valid = 1'b0;
    step();
    stall = 1'b1;
    step();
    check_ifid("hstall", 1'b1, 32'h20, 32'h24, 32'hFFFF_FFFF);
    check("hstall.halted", {31'b0, halted}, 32'h1);
    check("hstall.cnt", {28'b0, fetch_count}, 32'h1);
    rst = 1'b1;
    step();
    check_ifid("rst2", 1'b0, 32'h0, 32'h0, 32'h13);
    check("rst2.halted", {31'b0, halted}, 32'h0);
    check("rst2.cnt", {28'b0, fetch_count}, 32'h0);
    check("rst2.addr", imem_addr, 32'h0);
    rst = 1'b0; stall = 1'b0;
    step();
    check("boot2.valid", {31'b0, if_id_valid}, 32'h0);
    check("boot2.addr", imem_addr, 32'h0);
    step();
    check_ifid("boot2.f0", 1'b1, 32'h0, 32'h4, 32'h00A0_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
